// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial add/sub datapath: operation
// encodings, framer states and the bit-counter width helper.
package serial_pkg;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_PASS = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Bit-position counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_fa_slice.sv
// One channel of the serial unit: operand mapping, full adder, carry
// register and the per-bit overflow term (carry-in ^ carry-out).
module serial_fa_slice
    import serial_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       start,
    input  logic       busy,
    input  logic [1:0] mode_eff,
    input  logic       a,
    input  logic       b,
    output logic       z,
    output logic       ovf_term
);

    logic c;
    logic p, q, cin, ci, sum, co, bit_active;

    always_comb begin
        p   = a;
        q   = 1'b0;
        cin = 1'b0;
        case (mode_eff)
            MODE_ADD:  begin p = a;    q = b;  cin = 1'b0; end
            MODE_SUB:  begin p = a;    q = ~b; cin = 1'b1; end
            MODE_NEG:  begin p = 1'b0; q = ~a; cin = 1'b1; end
            MODE_PASS: begin p = a;    q = 1'b0; cin = 1'b0; end
            default:   begin p = a;    q = 1'b0; cin = 1'b0; end
        endcase
    end

    // A start bit seeds the carry from the new mode instead of the register.
    assign ci         = start ? cin : c;
    assign sum        = p ^ q ^ ci;
    assign co         = (p & q) | (p & ci) | (q & ci);
    assign bit_active = en & (busy | start);
    assign z          = bit_active ? sum : 1'b0;
    assign ovf_term   = ci ^ co;

    always_ff @(posedge clk) begin
        if (!reset) begin
            c <= 1'b0;
        end else if (bit_active) begin
            c <= co;
        end
    end

endmodule

// File: rtl/serial_addsub_n.sv
// N-channel LSB-first serial add/sub/neg/pass unit with a shared word
// framer; reports per-channel signed overflow with a done pulse per word.
module serial_addsub_n
    import serial_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] z,
    output logic         last,
    output logic         done,
    output logic [N-1:0] ovf,
    output logic         busy
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      mode_r, mode_n;
    logic [1:0]      mode_eff;
    logic [N-1:0]    ovf_terms;

    assign busy     = (state == ST_ACTIVE);
    assign mode_eff = start ? mode : mode_r;
    // A start on the MSB slot restarts rather than completes the word.
    assign last     = en & busy & ~start & (cnt == CNT_LAST);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mode_n  = mode_r;
        if (en) begin
            if (start) begin
                state_n = ST_ACTIVE;
                cnt_n   = CW'(1);
                mode_n  = mode;
            end else if (state == ST_ACTIVE) begin
                if (cnt == CNT_LAST) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mode_r <= MODE_ADD;
            done   <= 1'b0;
            ovf    <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mode_r <= mode_n;
            done   <= last;
            if (last) begin
                ovf <= ovf_terms;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        serial_fa_slice u_slice (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .start    (start),
            .busy     (busy),
            .mode_eff (mode_eff),
            .a        (a[i]),
            .b        (b[i]),
            .z        (z[i]),
            .ovf_term (ovf_terms[i])
        );
    end

endmodule
